row_fifo_skew_sched: RTL
========================

ROW_FIFO_SKEW_SCHED -- requirements
Module: row_fifo_skew_sched

Interface
REQ-001 Parameter ROW, default 9, number of row FIFOs / systolic-array rows (range 1..16).
REQ-002 Parameter LEN_W, default 8, width of the per-row word-count field.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_start  input  1  request to begin one skewed read wave; sampled only in IDLE.
REQ-006 i_len  input  LEN_W  words to read from each row FIFO; latched when i_start is accepted.
REQ-007 i_clear  input  1  synchronous abort; returns to IDLE without o_done.
REQ-008 i_fifo_empty  input  ROW  per-row FIFO empty flags, bit k = row k.
REQ-009 o_read_enable  output  ROW  per-row FIFO read strobes, bit k = row k.
REQ-010 o_busy  output  1  high in RUN and DONE states.
REQ-011 o_done  output  1  one-cycle pulse at wave completion.

Function
REQ-012 States SHALL be IDLE, RUN, DONE; encoding is implementation choice.
REQ-013 IDLE: i_start=1 SHALL latch i_len into len_q, clear counter cnt to 0, go to RUN; if i_len=0, go to DONE instead with no reads.
REQ-014 i_start in RUN or DONE SHALL be ignored (no queueing).
REQ-015 cnt width SHALL be LEN_W+5 bits; no overflow possible for legal ROW.
REQ-016 Row k SHALL be active in RUN when k <= cnt < k+len_q (row k lags row 0 by k cycles).
REQ-017 stall SHALL be OR over k of (active_k AND i_fifo_empty[k]), combinational.
REQ-018 o_read_enable[k] SHALL equal active_k AND NOT stall AND state==RUN, combinational from registered state and current inputs.
REQ-019 On stall, cnt and state SHALL hold and all read enables SHALL be 0, preserving skew alignment across rows.
REQ-020 In RUN without stall, cnt SHALL increment by 1; when cnt == len_q+ROW-2 and no stall, next state SHALL be DONE.
REQ-021 Each row SHALL therefore receive exactly len_q read strobes per wave; unstalled wave occupies len_q+ROW-1 RUN cycles.
REQ-022 DONE SHALL last exactly one cycle with o_done=1, then go to IDLE; o_done SHALL be 0 in all other states.
REQ-023 i_clear=1 SHALL force IDLE next cycle from any state, overriding i_start and completion; o_done SHALL not pulse.
REQ-024 i_rst SHALL take priority over i_clear and i_start.
REQ-025 i_fifo_empty bits for inactive rows SHALL have no effect.
REQ-026 Latency: i_start accepted at edge T -> first possible o_read_enable[0]=1 in cycle after T.

Reset
REQ-027 i_rst=1 at a clock edge SHALL set state=IDLE, cnt=0, len_q=0.
REQ-028 During and after reset, until a new i_start: o_read_enable=0, o_busy=0, o_done=0.
REQ-029 Reset mid-wave SHALL abandon the wave immediately; no o_done, no further strobes.

Verification
REQ-030 ROW=9, i_len=4, all FIFOs non-empty, i_start pulse -> row k strobes in RUN cycles k..k+3, 12 RUN cycles, o_done one cycle after last strobe on row 8, 4 strobes per row.
REQ-031 Same wave, i_fifo_empty[3]=1 for 2 cycles while row 3 active -> all enables 0 those 2 cycles, wave extends to 14 RUN cycles, still 4 strobes per row, skew intact.
REQ-032 i_len=0, i_start -> o_busy for 1 cycle, o_done pulse, zero strobes.
REQ-033 i_start re-asserted mid-wave, then i_clear at RUN cycle 5 -> second start ignored, IDLE next cycle, no o_done, no strobes after abort.
REQ-034 i_rst asserted at RUN cycle 3 with i_start also high -> next cycle all outputs 0, state IDLE; fresh i_start afterwards runs a complete correct wave.
REQ-035 i_len=255, ROW=9 -> 263 RUN cycles, 255 strobes per row, counter no wrap.

Source files
------------

// File: rtl/row_fifo_skew_sched.sv
// Skewed read scheduler for a bank of row FIFOs feeding a systolic array.
// Row k reads len words starting k cycles after row 0; any empty active row stalls every row.
module row_fifo_skew_sched #(
  parameter int unsigned ROW   = 9,
  parameter int unsigned LEN_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_clear,
  input  logic [ROW-1:0]   i_fifo_empty,
  output logic [ROW-1:0]   o_read_enable,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned CntW = LEN_W + 5;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [ROW-1:0]  active;
  logic            stall;
  logic [CntW-1:0] len_ext;
  logic [CntW-1:0] last_cnt;

  assign len_ext  = {5'b0, len_q};
  // Final step is when the last row (ROW-1) issues its last word.
  assign last_cnt = len_ext + CntW'(ROW) - CntW'(2);

  always_comb begin
    active = '0;
    for (int unsigned k = 0; k < ROW; k++) begin
      active[k] = (cnt_q >= CntW'(k)) && (cnt_q < CntW'(k) + len_ext);
    end
  end

  // A single empty active row freezes the whole wave so the skew between rows is kept.
  assign stall = (state_q == StRun) && |(active & i_fifo_empty);

  assign o_read_enable = ((state_q == StRun) && !stall) ? active : '0;
  assign o_busy        = (state_q != StIdle);
  assign o_done        = (state_q == StDone);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          len_d   = i_len;
          cnt_d   = '0;
          state_d = (i_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (!stall) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == last_cnt) begin
            state_d = StDone;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (i_clear) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

endmodule
